// File: rtl/priority_encoder8x3.sv
// Registered 8-to-3 priority encoder with request buffering and valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (index 7 highest).
module priority_encoder8x3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [2:0] address,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       idle
);

`ifdef ROUND_ROBIN_EN
  // Search ascending from last+1 with wrap; the eighth probe revisits last itself.
  function automatic logic [2:0] sel_rr(input logic [7:0] vec, input logic [2:0] last);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (vec[idx] && !found) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic [2:0] last_r;
`else
  // Ascending scan overwrites the result, so the highest set index wins.
  function automatic logic [2:0] sel_fixed(input logic [7:0] vec);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        r = 3'(i);
      end
    end
    return r;
  endfunction
`endif

  logic [2:0] sel_s;
  logic       fire_s;
  logic       load_s;
  logic [7:0] onehot_s;
  logic [7:0] pending_next_s;

  // Selection, handshake qualifiers and next pending set (req is OR-ed last so set wins).
  always_comb begin
`ifdef ROUND_ROBIN_EN
    sel_s = sel_rr(pending, last_r);
`else
    sel_s = sel_fixed(pending);
`endif
    fire_s         = valid & ready;
    load_s         = (~valid | ready) & (|pending);
    onehot_s       = load_s ? (8'd1 << sel_s) : 8'd0;
    pending_next_s = (pending & ~onehot_s) | req;
  end

  // Pending set, output register and handshake state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 8'd0;
      address <= 3'd0;
      valid   <= 1'b0;
    end else begin
      pending <= pending_next_s;
      if (load_s) begin
        address <= sel_s;
        valid   <= 1'b1;
      end else if (fire_s) begin
        valid   <= 1'b0;
      end
    end
  end

`ifdef ROUND_ROBIN_EN
  // Last granted index; resets to 7 so the first search starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 3'd7;
    end else if (load_s) begin
      last_r <= sel_s;
    end
  end
`endif

  assign idle = ~valid & ~(|pending);

endmodule

// File: tb/tb_priority_encoder8x3.sv
// Self-checking bench for priority_encoder8x3: vector table plus hand-written corner sequences.
module tb_priority_encoder8x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       ready = 1'b0;
  logic [2:0] address;
  logic       valid;
  logic [7:0] pending;
  logic       idle;

  priority_encoder8x3 dut (
    .clk(clk), .rst_n(rst_n), .req(req), .address(address),
    .valid(valid), .ready(ready), .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    int         n;
    logic [2:0] exp [8];
  } vec_t;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [2:0] exp_q [$];
  logic [2:0] got_q [$];

  // Record every accepted transfer; the comparison happens against exp_q.
  always @(negedge clk) begin
    if (rst_n && valid && ready) got_q.push_back(address);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    check({name, "_count"}, 8'(got_q.size()), 8'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, "_addr"}, 8'(got_q.pop_front()), 8'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!idle && k < 64) begin
      tick();
      k++;
    end
    check({name, "_idle"}, 8'(idle), 8'd1);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0].req = 8'hA4; vecs[0].n = 3; vecs[0].exp = '{3'd7, 3'd5, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[1].req = 8'h01; vecs[1].n = 1; vecs[1].exp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[2].req = 8'h5A; vecs[2].n = 4; vecs[2].exp = '{3'd6, 3'd4, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[3].req = 8'h80; vecs[3].n = 1; vecs[3].exp = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[4].req = 8'hC3; vecs[4].n = 4; vecs[4].exp = '{3'd7, 3'd6, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    // Reset state
    repeat (2) tick();
    check("rst_valid", 8'(valid), 8'd0);
    check("rst_pending", pending, 8'd0);
    check("rst_address", 8'(address), 8'd0);
    check("rst_idle", 8'(idle), 8'd1);
    rst_n = 1'b1;
    tick();

`ifndef ROUND_ROBIN_EN
    // Table: one-cycle pulses, ready high, grants in descending index order
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].exp[j]);
      req = vecs[i].req;
      ready = 1'b1;
      tick();
      req = 8'd0;
      check("tbl_pending", pending, vecs[i].req);
      check("tbl_latency", 8'(valid), 8'd0);
      repeat (vecs[i].n + 1) tick();
      check("tbl_valid_drop", 8'(valid), 8'd0);
      check("tbl_idle", 8'(idle), 8'd1);
      drain("tbl");
    end

    // Backpressure: 8'h81 pulse, ready low for 5 cycles
    exp_q.push_back(3'd7);
    exp_q.push_back(3'd0);
    req = 8'h81;
    ready = 1'b0;
    tick();
    req = 8'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 8'(valid), 8'd1);
      check("bp_address", 8'(address), 8'd7);
      check("bp_pending", pending, 8'h01);
    end
    ready = 1'b1;
    tick();
    check("bp_addr0", 8'(address), 8'd0);
    check("bp_valid0", 8'(valid), 8'd1);
    tick();
    check("bp_drop", 8'(valid), 8'd0);
    check("bp_idle", 8'(idle), 8'd1);
    drain("bp");

    // Set wins / re-arm: req[3] held for 6 cycles gives exactly 6 grants
    for (int k = 0; k < 6; k++) exp_q.push_back(3'd3);
    req = 8'h08;
    ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sw_valid", 8'(valid), 8'd1);
      check("sw_address", 8'(address), 8'd3);
      check("sw_pending3", 8'(pending[3]), 8'd1);
    end
    req = 8'd0;
    tick();
    check("sw_last_valid", 8'(valid), 8'd1);
    check("sw_last_pending", pending, 8'd0);
    tick();
    check("sw_drop", 8'(valid), 8'd0);
    check("sw_idle", 8'(idle), 8'd1);
    drain("sw");

    // All requests held: fixed priority grants 7 every cycle, then drains downward
    for (int k = 0; k < 4; k++) exp_q.push_back(3'd7);
    for (int k = 6; k >= 0; k--) exp_q.push_back(3'(k));
    req = 8'hFF;
    ready = 1'b1;
    repeat (4) tick();
    req = 8'd0;
    wait_idle("ff_fixed");
    drain("ff_fixed");
`else
    // All requests held: rotating priority starting at index 0 after reset
    for (int k = 0; k < 10; k++) exp_q.push_back(3'(k));
    for (int k = 2; k < 8; k++) exp_q.push_back(3'(k));
    exp_q.push_back(3'd0);
    req = 8'hFF;
    ready = 1'b1;
    repeat (10) tick();
    req = 8'd0;
    wait_idle("ff_rr");
    drain("ff_rr");
`endif

    // Reset during the second grant of a 8'h3C pulse
`ifdef ROUND_ROBIN_EN
    exp_q.push_back(3'd2);
`else
    exp_q.push_back(3'd5);
`endif
    req = 8'h3C;
    ready = 1'b1;
    tick();
    req = 8'd0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_valid", 8'(valid), 8'd0);
    check("mr_pending", pending, 8'd0);
    check("mr_address", 8'(address), 8'd0);
    check("mr_idle", 8'(idle), 8'd1);
    drain("mr");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mr_post_idle", 8'(idle), 8'd1);
    end
    check("mr_no_grant", 8'(got_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder8x3.md
# priority_encoder8x3

Registered 8-to-3 priority encoder with request buffering. It is the inverse of the 3x8 address decoder. It collects up to eight request lines into a pending set and encodes one pending line per transfer into a 3-bit address. Each address is presented on a valid/ready handshake, so a downstream decoder or consumer can apply backpressure. Requests are never lost while waiting.

## Interface
- Parameters: none. Request width is fixed at 8 and address width at 3.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request lines, sampled every cycle; a 1-cycle pulse is sufficient
- address  output  3  encoded index of the granted request (registered)
- valid  output  1  address holds a grant (registered)
- ready  input  1  consumer accepts address this cycle
- pending  output  8  requests latched and not yet moved to the output (registered)
- idle  output  1  combinational: ~valid & ~|pending

## Operation
- State registers: pending[7:0], address[2:0], valid, and last[2:0] (used only in round-robin builds).
- fire = valid & ready.
- load = (~valid | ready) & |pending.
- sel is the selected index over pending (see Configuration). onehot(sel) is its 8-bit one-hot form.
- On load:
  - address <= sel, valid <= 1.
  - The sel bit is removed from pending, so an in-flight grant is never also pending.
- On fire without load: valid <= 0. address holds its last value.
- pending_next = (pending & ~(load ? onehot(sel) : 0)) | req.
- Set wins: a req bit that is high in the same cycle its pending bit is loaded stays pending.
- A req for an index that is currently in flight re-arms that index; it is granted again later.
- Multiple req bits in one cycle all latch.
- Held requests re-latch every cycle.
- Selection depends only on registered pending. req never bypasses into address.

## Timing
- Reset values: pending=0, address=0, valid=0, last=7. idle=1 during reset.
- Latency: req high in cycle n → pending bit set after edge n+1 → valid=1 with that address after edge n+2 (if the output is free).
- Throughput: one grant per cycle while ready=1 and pending≠0 (back-to-back fire/load).
- Backpressure: while valid & ~ready, address and valid hold stable and pending only accumulates.
- valid drops on the edge after the last fire when pending=0.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronously).
  - The in-flight grant and all pending requests are discarded.
  - The first possible grant after deassertion needs a fresh req.

## Configuration
- ROUND_ROBIN_EN not defined: fixed priority.
  - The highest set index of pending wins (7 highest, 0 lowest).
  - last is unused and may be optimized away.
  - Held high-index requests starve lower ones; this is intended.
- ROUND_ROBIN_EN defined: rotating priority.
  - The search starts at (last+1) mod 8, ascending with wrap 7→0.
  - The first set pending bit wins.
  - last <= sel on every load.
  - The first grant after reset searches from index 0.

## Test plan
- Fixed priority, req=8'hA4 for 1 cycle, ready=1:
  - address 7, 5, 2 on three consecutive valid cycles, starting 2 cycles after req.
  - Then valid=0 and idle=1.
- Backpressure, req=8'h81 pulse, ready=0 for 5 cycles:
  - address=7 with valid=1 held stable; pending=8'h01.
  - After ready=1: address 0 on the next cycle, then valid=0.
- Set-wins / re-arm: req[3] held high, ready=1, fixed priority.
  - address=3 with valid continuously 1; pending[3] stays 1.
  - Drop req[3]: exactly one more grant of 3, then idle.
- Round-robin (ROUND_ROBIN_EN), req=8'hFF held, ready=1:
  - address sequence 0,1,2,…,7,0,1 on consecutive cycles.
  - Same stimulus without the macro: address 7 every cycle.
- Reset mid-operation, req=8'h3C pulse, then rst_n=0 during the second grant:
  - valid=0, pending=0, address=0 immediately.
  - After rst_n=1 with no req: idle stays 1.
